// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack-pop FSM states, flag width and pop word counts.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_LO  = 3'd1,
        POP_HI  = 3'd2,
        POP_FLG = 3'd3,
        FINISH  = 3'd4
    } pop_state_e;

    localparam int FLAG_W    = 4;
    localparam int RET_WORDS = 2;
    localparam int RTI_WORDS = 3;

endpackage

// File: rtl/stack_pop_ctrl.sv
// RET/RTI stack pop sequencer: reads PC (and flags for RTI) from the stack.
// Optional underflow/bound check enabled by macro STACK_POP_BOUND_CHECK_EN.
module stack_pop_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] STACK_TOP = 32'h000F_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ret,
    input  logic              i_rti,
    input  logic [31:0]       i_sp,
    output logic              o_mem_rd,
    output logic [31:0]       o_mem_addr,
    input  logic [15:0]       i_mem_data,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_pc,
    output logic [FLAG_W-1:0] o_flags,
    output logic              o_sp_we,
    output logic [31:0]       o_sp_new,
    output logic              o_stack_err
);

    pop_state_e        state_q, state_d;
    logic [31:0]       sp_q, sp_d;
    logic              rti_q, rti_d;
    logic [15:0]       lo_q, lo_d;
    logic [15:0]       hi_q, hi_d;
    logic [31:0]       pc_q, pc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic              req;
    logic              over;
    logic [31:0]       fin_pc;
    logic [FLAG_W-1:0] fin_flags;
    logic [31:0]       words_q;

    assign req     = i_ret | i_rti;
    assign words_q = rti_q ? 32'(RTI_WORDS) : 32'(RET_WORDS);

`ifdef STACK_POP_BOUND_CHECK_EN
    logic        err_q, err_d;
    logic [32:0] sp_end;

    // 33-bit sum so a wrap past 2^32 still counts as out of range
    assign sp_end = {1'b0, i_sp} + (i_rti ? 33'(RTI_WORDS) : 33'(RET_WORDS));
    assign over   = sp_end > {1'b0, STACK_TOP};
    assign err_d  = (state_q == IDLE) && req && over;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign o_stack_err = err_q;
`else
    logic unused_top;
    assign unused_top  = ^STACK_TOP;
    assign over        = 1'b0;
    assign o_stack_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            rti_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            rti_q   <= rti_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    // Last word arrives during FINISH, so the result is forwarded straight out
    assign fin_pc    = {rti_q ? hi_q : i_mem_data, lo_q};
    assign fin_flags = rti_q ? i_mem_data[FLAG_W-1:0] : '0;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        rti_d   = rti_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (req && !over) begin
                    sp_d    = i_sp;
                    rti_d   = i_rti;
                    state_d = POP_LO;
                end
            end
            POP_LO:  state_d = POP_HI;
            POP_HI: begin
                lo_d    = i_mem_data;
                state_d = rti_q ? POP_FLG : FINISH;
            end
            POP_FLG: begin
                hi_d    = i_mem_data;
                state_d = FINISH;
            end
            FINISH: begin
                pc_d    = fin_pc;
                flags_d = fin_flags;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        o_stall    = 1'b0;
        o_done     = 1'b0;
        o_sp_we    = 1'b0;
        o_sp_new   = '0;
        o_pc       = pc_q;
        o_flags    = flags_q;
        case (state_q)
            IDLE:    o_stall = req && !over && rst;
            POP_LO: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = sp_q + 32'd1;
                o_stall    = 1'b1;
            end
            POP_HI: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = sp_q + 32'd2;
                o_stall    = 1'b1;
            end
            POP_FLG: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = sp_q + 32'd3;
                o_stall    = 1'b1;
            end
            FINISH: begin
                o_done   = 1'b1;
                o_sp_we  = 1'b1;
                o_sp_new = sp_q + words_q;
                o_pc     = fin_pc;
                o_flags  = fin_flags;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_pop_ctrl.sv
// Directed table-driven bench for stack_pop_ctrl with a one-cycle-latency memory model.
module tb_stack_pop_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ret, i_rti;
    logic [31:0] i_sp;
    logic        o_mem_rd;
    logic [31:0] o_mem_addr;
    logic [15:0] i_mem_data;
    logic        o_stall, o_done, o_sp_we, o_stack_err;
    logic [31:0] o_pc, o_sp_new;
    logic [3:0]  o_flags;

    int ncmp = 0;
    int errs = 0;

    stack_pop_ctrl dut (
        .clk(clk), .rst(rst), .i_ret(i_ret), .i_rti(i_rti), .i_sp(i_sp),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_stall(o_stall), .o_done(o_done), .o_pc(o_pc), .o_flags(o_flags),
        .o_sp_we(o_sp_we), .o_sp_new(o_sp_new), .o_stack_err(o_stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0FF1: memf = 16'h1234;
            32'h0000_0FF2: memf = 16'h0005;
            32'h0000_0FF3: memf = 16'h000A;
            default:       memf = a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Read data shows up in the cycle after the strobe
    initial begin
        logic        pr;
        logic [31:0] pa;
        i_mem_data = 16'hDEAD;
        forever begin
            @(negedge clk);
            pr = o_mem_rd;
            pa = o_mem_addr;
            @(posedge clk);
            #1;
            i_mem_data = pr ? memf(pa) : 16'hDEAD;
        end
    end

    typedef struct {
        logic            ret;
        logic            rti;
        logic            pulse;
        logic [31:0]     sp;
        int              n_rd;
        logic [2:0][31:0] a;
        logic [31:0]     pc;
        logic [3:0]      flg;
        logic [31:0]     sp_new;
        int              cyc;
    } vec_t;

    function automatic vec_t mk(input logic ret, input logic rti, input logic pulse,
                                input logic [31:0] sp, input int n_rd,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] pc,
                                input logic [3:0] flg, input logic [31:0] sp_new,
                                input int cyc);
        vec_t v;
        v.ret = ret; v.rti = rti; v.pulse = pulse; v.sp = sp; v.n_rd = n_rd;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.pc = pc; v.flg = flg; v.sp_new = sp_new; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after the
    // negedge of the cycle following FINISH.
    task automatic run_pop(input vec_t v, input string tag);
        bit got = 0;
        i_ret = v.ret;
        i_rti = v.rti;
        i_sp  = v.sp;
        #1;
        chk({tag, " stall_req"}, 32'(o_stall), 32'd1);
        chk({tag, " rd_req"}, 32'(o_mem_rd), 32'd0);
        @(posedge clk);
        #1;
        i_ret = 1'b0;
        i_rti = 1'b0;
        i_sp  = 32'hBAD0_BAD0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (o_done) begin
                chk({tag, " done_cycle"}, 32'(c), 32'(v.cyc));
                chk({tag, " pc"}, o_pc, v.pc);
                chk({tag, " flags"}, 32'(o_flags), 32'(v.flg));
                chk({tag, " sp_we"}, 32'(o_sp_we), 32'd1);
                chk({tag, " sp_new"}, o_sp_new, v.sp_new);
                chk({tag, " stall_fin"}, 32'(o_stall), 32'd0);
                chk({tag, " rd_fin"}, 32'(o_mem_rd), 32'd0);
                got = 1;
                break;
            end
            chk({tag, " rd"}, 32'(o_mem_rd), 32'd1);
            chk({tag, " stall"}, 32'(o_stall), 32'd1);
            if (c <= v.n_rd) chk({tag, " addr"}, o_mem_addr, v.a[c-1]);
            if (c == 2 && v.pulse) i_ret = 1'b1;
            if (c == 3) i_ret = 1'b0;
        end
        i_ret = 1'b0;
        if (!got) begin
            ncmp++;
            errs++;
            $display("FAIL %s done_timeout: got no o_done want o_done by cycle %0d", tag, v.cyc);
            return;
        end
        @(negedge clk);
        chk({tag, " hold_pc"}, o_pc, v.pc);
        chk({tag, " hold_flags"}, 32'(o_flags), 32'(v.flg));
        chk({tag, " idle_done"}, 32'(o_done), 32'd0);
        chk({tag, " idle_sp_we"}, 32'(o_sp_we), 32'd0);
        chk({tag, " idle_sp_new"}, o_sp_new, 32'd0);
        chk({tag, " idle_addr"}, o_mem_addr, 32'd0);
        chk({tag, " stack_err"}, 32'(o_stack_err), 32'd0);
    endtask

    vec_t vec [4];

    initial begin
        vec[0] = mk(1, 0, 0, 32'h0000_0FF0, 2, 32'h0FF1, 32'h0FF2, 32'h0,
                    32'h0005_1234, 4'h0, 32'h0000_0FF2, 3);
        vec[1] = mk(0, 1, 0, 32'h0000_0FF0, 3, 32'h0FF1, 32'h0FF2, 32'h0FF3,
                    32'h0005_1234, 4'hA, 32'h0000_0FF3, 4);
        vec[2] = mk(1, 1, 1, 32'h0000_0FF0, 3, 32'h0FF1, 32'h0FF2, 32'h0FF3,
                    32'h0005_1234, 4'hA, 32'h0000_0FF3, 4);
        vec[3] = mk(1, 0, 0, 32'hFFFF_FFFF, 2, 32'h0, 32'h1, 32'h0,
                    32'h5A5B_5A5A, 4'h0, 32'h0000_0001, 3);

        rst = 1'b0; i_ret = 1'b0; i_rti = 1'b0; i_sp = '0;
        #1;
        chk("rst_rd", 32'(o_mem_rd), 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_flags", 32'(o_flags), 32'd0);
        chk("rst_sp_we", 32'(o_sp_we), 32'd0);
        chk("rst_err", 32'(o_stack_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back pops: each starts in the cycle after the previous FINISH
        for (int i = 0; i < 4; i++) run_pop(vec[i], $sformatf("vec%0d", i));

        // Reset during POP_HI of a RET
        i_ret = 1'b1; i_sp = 32'h0000_0FF0;
        @(posedge clk);
        #1;
        i_ret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_addr", o_mem_addr, 32'h0000_0FF2);
        rst = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(o_mem_rd), 32'd0);
        chk("mid_rst_addr", o_mem_addr, 32'd0);
        chk("mid_rst_stall", 32'(o_stall), 32'd0);
        chk("mid_rst_pc", o_pc, 32'd0);
        i_ret = 1'b1;
        #1;
        chk("mid_rst_req_stall", 32'(o_stall), 32'd0);
        i_ret = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_done", 32'(o_done), 32'd0);
            chk("mid_rst_sp_we", 32'(o_sp_we), 32'd0);
        end
        rst = 1'b1;
        run_pop(vec[0], "after_rst");

`ifdef STACK_POP_BOUND_CHECK_EN
        i_rti = 1'b1; i_sp = 32'h000F_FFFE;
        #1;
        chk("bound_stall", 32'(o_stall), 32'd0);
        @(posedge clk);
        #1;
        i_rti = 1'b0;
        @(negedge clk);
        chk("bound_err", 32'(o_stack_err), 32'd1);
        chk("bound_rd", 32'(o_mem_rd), 32'd0);
        chk("bound_done", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("bound_err_clr", 32'(o_stack_err), 32'd0);
        chk("bound_rd2", 32'(o_mem_rd), 32'd0);
`else
        run_pop(mk(0, 1, 0, 32'h000F_FFFE, 3, 32'h000F_FFFF, 32'h0010_0000,
                   32'h0010_0001, 32'h5A5A_A5A5, 4'hB, 32'h0010_0001, 4), "nobound");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, errs);
        $finish;
    end

endmodule
